gfx_rom_arbiter: RTL and testbench

Shares a single pair of graphics-ROM SDRAM slots (lower half / upper half) between the four GP9001 fetch requesters: sprites, scroll 0, scroll 1 and scroll 2. It sits between the AFBK_CT2-style address translators and the SDRAM controller. Address translation and bank selection stay upstream. The block arbitrates, latches the winning address, runs the CS/OK handshake, returns raw 32-bit ROM words, and guards against a stalled SDRAM slot with a watchdog.

---
 rtl/gfx_rom_arbiter.sv | 143 ++++++++++++++
 tb/tb_gfx_rom_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_rom_arbiter.sv
// rtl/gfx_rom_arbiter.sv - shares the two graphics-ROM SDRAM slots between the four GP9001 fetchers
// Arbitrates, latches the winning address, runs the CS/OK handshake and aborts stalled fetches.
`timescale 1ns/1ps
module gfx_rom_arbiter #(
  parameter int TIMEOUT     = 255,
  parameter bit SPRITE_PRIO = 1'b1
) (
  input  logic        CLK96,
  input  logic        RESET96,
  input  logic [3:0]  REQ_CS,
  input  logic [3:0]  REQ_HALF,
  input  logic [87:0] REQ_ADDR,
  output logic [3:0]  REQ_OK,
  output logic [31:0] REQ_DATA,
  output logic        TIMEOUT_ERR,
  output logic        BUSY,
  output logic [1:0]  GFX_CS,
  input  logic [1:0]  GFX_OK,
  output logic [21:0] GFX0_ADDR,
  input  logic [31:0] GFX0_DOUT,
  output logic [21:0] GFX1_ADDR,
  input  logic [31:0] GFX1_DOUT
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  localparam logic [9:0] TMO = 10'(TIMEOUT);

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [1:0]  gnt, gnt_nxt;
  logic        half, half_nxt;
  logic [9:0]  cnt, cnt_nxt;
  logic [1:0]  cs_nxt;
  logic [21:0] a0_nxt, a1_nxt;
  logic [3:0]  ok_nxt;
  logic [31:0] data_nxt;
  logic        err_nxt;

  logic [1:0]  win;
  logic [21:0] req_addr_w [4];
  logic        ok_sel;
  logic [31:0] dout_sel;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_addr_w[i] = REQ_ADDR[22*i +: 22];
    end
  end

  // Scan from farthest to nearest so the requester right after ptr overrides the rest.
  always_comb begin
    win = ptr;
    for (int i = 4; i >= 1; i--) begin
      if (REQ_CS[ptr + 2'(i)]) win = ptr + 2'(i);
    end
    if (SPRITE_PRIO && REQ_CS[0]) win = 2'd0;
  end

  assign ok_sel   = half ? GFX_OK[1] : GFX_OK[0];
  assign dout_sel = half ? GFX1_DOUT : GFX0_DOUT;
  assign BUSY     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    half_nxt  = half;
    cnt_nxt   = cnt;
    cs_nxt    = GFX_CS;
    a0_nxt    = GFX0_ADDR;
    a1_nxt    = GFX1_ADDR;
    ok_nxt    = 4'b0000;
    data_nxt  = REQ_DATA;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|REQ_CS) begin
          gnt_nxt  = win;
          ptr_nxt  = win;
          half_nxt = REQ_HALF[win];
          cnt_nxt  = 10'd0;
          cs_nxt   = REQ_HALF[win] ? 2'b10 : 2'b01;
          if (REQ_HALF[win]) a1_nxt = req_addr_w[win];
          else               a0_nxt = req_addr_w[win];
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // cnt==0 is the first WAIT cycle; an OK there may be left over from the previous fetch.
        if (cnt != 10'd0 && ok_sel) begin
          data_nxt    = dout_sel;
          ok_nxt[gnt] = 1'b1;
          cs_nxt      = 2'b00;
          state_nxt   = ACK;
        end else if (cnt == TMO) begin
          data_nxt    = 32'd0;
          ok_nxt[gnt] = 1'b1;
          err_nxt     = 1'b1;
          cs_nxt      = 2'b00;
          state_nxt   = ACK;
        end else if (cnt != 10'h3FF) begin
          cnt_nxt = cnt + 10'd1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      state       <= IDLE;
      ptr         <= 2'd3;
      gnt         <= 2'd0;
      half        <= 1'b0;
      cnt         <= 10'd0;
      GFX_CS      <= 2'b00;
      GFX0_ADDR   <= 22'd0;
      GFX1_ADDR   <= 22'd0;
      REQ_OK      <= 4'b0000;
      REQ_DATA    <= 32'd0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      gnt         <= gnt_nxt;
      half        <= half_nxt;
      cnt         <= cnt_nxt;
      GFX_CS      <= cs_nxt;
      GFX0_ADDR   <= a0_nxt;
      GFX1_ADDR   <= a1_nxt;
      REQ_OK      <= ok_nxt;
      REQ_DATA    <= data_nxt;
      TIMEOUT_ERR <= err_nxt;
    end
  end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// tb/tb_gfx_rom_arbiter.sv - bench for gfx_rom_arbiter
// Instance 0 runs with sprite priority, instance 1 pure round-robin; both with TIMEOUT=8.
`timescale 1ns/1ps
module tb_gfx_rom_arbiter;

  localparam int TMO = 8;

  logic CLK96 = 1'b0;
  logic RESET96;
  always #5 CLK96 = ~CLK96;

  logic [3:0]  req_cs    [2];
  logic [3:0]  req_half  [2];
  logic [87:0] req_addr  [2];
  logic [3:0]  req_ok    [2];
  logic [31:0] req_data  [2];
  logic        tmo_err   [2];
  logic        busy      [2];
  logic [1:0]  gfx_cs    [2];
  logic [1:0]  gfx_ok    [2];
  logic [1:0]  ok_drv    [2];
  logic        auto_ok   [2];
  logic [21:0] gfx0_addr [2];
  logic [21:0] gfx1_addr [2];
  logic [31:0] gfx0_dout [2];
  logic [31:0] gfx1_dout [2];

  assign gfx_ok[0] = auto_ok[0] ? gfx_cs[0] : ok_drv[0];
  assign gfx_ok[1] = auto_ok[1] ? gfx_cs[1] : ok_drv[1];

  gfx_rom_arbiter #(.TIMEOUT(TMO), .SPRITE_PRIO(1'b1)) dut_p (
    .CLK96(CLK96), .RESET96(RESET96),
    .REQ_CS(req_cs[0]), .REQ_HALF(req_half[0]), .REQ_ADDR(req_addr[0]),
    .REQ_OK(req_ok[0]), .REQ_DATA(req_data[0]), .TIMEOUT_ERR(tmo_err[0]), .BUSY(busy[0]),
    .GFX_CS(gfx_cs[0]), .GFX_OK(gfx_ok[0]),
    .GFX0_ADDR(gfx0_addr[0]), .GFX0_DOUT(gfx0_dout[0]),
    .GFX1_ADDR(gfx1_addr[0]), .GFX1_DOUT(gfx1_dout[0])
  );

  gfx_rom_arbiter #(.TIMEOUT(TMO), .SPRITE_PRIO(1'b0)) dut_r (
    .CLK96(CLK96), .RESET96(RESET96),
    .REQ_CS(req_cs[1]), .REQ_HALF(req_half[1]), .REQ_ADDR(req_addr[1]),
    .REQ_OK(req_ok[1]), .REQ_DATA(req_data[1]), .TIMEOUT_ERR(tmo_err[1]), .BUSY(busy[1]),
    .GFX_CS(gfx_cs[1]), .GFX_OK(gfx_ok[1]),
    .GFX0_ADDR(gfx0_addr[1]), .GFX0_DOUT(gfx0_dout[1]),
    .GFX1_ADDR(gfx1_addr[1]), .GFX1_DOUT(gfx1_dout[1])
  );

  typedef struct {
    int          req;
    logic        half;
    logic [21:0] addr;
    int          k;
    bit          stale;
    bit          noise;
    bit          drop;
    logic [31:0] dout;
    int          exp_lat;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;

  vec_t        vecs [8];
  int          passed = 0;
  int          total  = 0;
  logic [21:0] ea0, ea1;
  logic [3:0]  okv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic int pick(input logic [3:0] p, input int last, input bit prio);
    if (prio && p[0]) return 0;
    for (int i = 1; i <= 4; i++) begin
      if (p[(last + i) % 4]) return (last + i) % 4;
    end
    return 0;
  endfunction

  task automatic wait_ok(input int d, output logic [3:0] o);
    o = 4'b0000;
    for (int n = 0; n < 60; n++) begin
      @(posedge CLK96); #1;
      if (req_ok[d] != 4'b0000) begin
        o = req_ok[d];
        break;
      end
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    logic [1:0] sel, oth, okb;
    int lat;
    bit got;
    sel = v.half ? 2'b10 : 2'b01;
    oth = ~sel;
    req_half[0][v.req] = v.half;
    req_addr[0][22*v.req +: 22] = v.addr;
    req_cs[0] = 4'b0001 << v.req;
    gfx0_dout[0] = v.half ? ~v.dout : v.dout;
    gfx1_dout[0] = v.half ? v.dout : ~v.dout;
    ok_drv[0] = (v.stale ? sel : 2'b00) | (v.noise ? oth : 2'b00);
    @(posedge CLK96); #1;
    if (v.half) ea1 = v.addr;
    else        ea0 = v.addr;
    chk($sformatf("v%0d_grant_cs", vi), gfx_cs[0], sel);
    chk($sformatf("v%0d_grant_a0", vi), gfx0_addr[0], ea0);
    chk($sformatf("v%0d_grant_a1", vi), gfx1_addr[0], ea1);
    chk($sformatf("v%0d_busy", vi), busy[0], 1'b1);
    req_addr[0][22*v.req +: 22] = ~v.addr;
    req_half[0][v.req] = ~v.half;
    if (v.drop) req_cs[0] = 4'b0000;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      okb = v.noise ? oth : 2'b00;
      if (lat == v.k || (v.stale && lat == 0)) okb = okb | sel;
      ok_drv[0] = okb;
      @(posedge CLK96); #1;
      lat++;
      if (req_ok[0] != 4'b0000) got = 1;
    end
    chk($sformatf("v%0d_latency", vi), lat, v.exp_lat);
    chk($sformatf("v%0d_req_ok", vi), req_ok[0], 4'b0001 << v.req);
    chk($sformatf("v%0d_data", vi), req_data[0], v.exp_data);
    chk($sformatf("v%0d_err", vi), tmo_err[0], v.exp_err);
    chk($sformatf("v%0d_cs_done", vi), gfx_cs[0], 2'b00);
    chk($sformatf("v%0d_addr_hold", vi), {gfx1_addr[0], gfx0_addr[0]}, {ea1, ea0});
    req_cs[0] = 4'b0000;
    ok_drv[0] = 2'b00;
    @(posedge CLK96); #1;
    chk($sformatf("v%0d_ack_clear", vi), {req_ok[0], tmo_err[0], busy[0]}, 6'd0);
    chk($sformatf("v%0d_data_held", vi), req_data[0], v.exp_data);
  endtask

  task automatic run_random(input int d, input bit prio, input int ncyc);
    logic [3:0]  pend, done_m;
    logic        halfv [4];
    logic [21:0] addrv [4];
    logic [1:0]  okp;
    logic [31:0] d0p, d1p;
    logic        half_m;
    logic [21:0] addr_m;
    int          last, cur, widx, free_at;
    bit          busy_m, fin, tmo;
    req_cs[d] = 4'b0000;
    ok_drv[d] = 2'b00;
    auto_ok[d] = 1'b0;
    RESET96 = 1'b1;
    @(posedge CLK96); #1;
    RESET96 = 1'b0;
    pend = 4'b0000; last = 3; cur = 0; widx = 0; free_at = 0; busy_m = 0;
    half_m = 1'b0; addr_m = 22'd0; okp = 2'b00; d0p = 32'd0; d1p = 32'd0;
    for (int r = 0; r < 4; r++) begin
      halfv[r] = 1'b0;
      addrv[r] = 22'd0;
    end
    for (int e = 1; e <= ncyc; e++) begin
      @(posedge CLK96); #1;
      done_m = 4'b0000;
      if (busy_m) begin
        fin = (widx >= 1) && okp[half_m];
        tmo = !fin && (widx == TMO);
        if (fin || tmo) begin
          chk("rand_ok", req_ok[d], 4'b0001 << cur);
          chk("rand_data", req_data[d], fin ? (half_m ? d1p : d0p) : 32'd0);
          chk("rand_err", tmo_err[d], tmo);
          chk("rand_cs_done", gfx_cs[d], 2'b00);
          busy_m = 0;
          free_at = e + 2;
          pend[cur] = 1'b0;
          done_m[cur] = 1'b1;
        end else begin
          chk("rand_wait", {req_ok[d], gfx_cs[d]}, {4'b0000, half_m ? 2'b10 : 2'b01});
          widx++;
        end
      end else if (e >= free_at && pend != 4'b0000) begin
        cur = pick(pend, last, prio);
        last = cur;
        half_m = halfv[cur];
        addr_m = addrv[cur];
        chk("rand_grant_cs", gfx_cs[d], half_m ? 2'b10 : 2'b01);
        chk("rand_grant_addr", half_m ? gfx1_addr[d] : gfx0_addr[d], addr_m);
        busy_m = 1;
        widx = 0;
        halfv[cur] = 1'($urandom_range(0, 1));
        addrv[cur] = 22'($urandom);
      end else begin
        chk("rand_idle", {req_ok[d], gfx_cs[d]}, 6'd0);
      end
      for (int r = 0; r < 4; r++) begin
        if (!pend[r] && !done_m[r] && e < ncyc - 60 && $urandom_range(0, 3) == 0) begin
          pend[r] = 1'b1;
          halfv[r] = 1'($urandom_range(0, 1));
          addrv[r] = 22'($urandom);
        end
      end
      okp = ((e / 40) % 4 == 3) ? 2'b00 : 2'($urandom_range(0, 3));
      d0p = $urandom;
      d1p = $urandom;
      req_cs[d] = pend;
      for (int r = 0; r < 4; r++) begin
        req_half[d][r] = halfv[r];
        req_addr[d][22*r +: 22] = addrv[r];
      end
      ok_drv[d] = okp;
      gfx0_dout[d] = d0p;
      gfx1_dout[d] = d1p;
    end
    chk("rand_drained", {pend, busy_m}, 5'd0);
    req_cs[d] = 4'b0000;
    ok_drv[d] = 2'b00;
  endtask

  initial begin
    vecs[0] = '{2, 1'b1, 22'h012345, 1,  1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{0, 1'b0, 22'h3FFFFF, 3,  1'b0, 1'b0, 1'b1, 32'h01234567, 4, 32'h01234567, 1'b0};
    vecs[2] = '{1, 1'b0, 22'h000001, 1,  1'b1, 1'b0, 1'b0, 32'hA5A55A5A, 2, 32'hA5A55A5A, 1'b0};
    vecs[3] = '{3, 1'b0, 22'h2AAAAA, 2,  1'b0, 1'b1, 1'b0, 32'h0F0F0F0F, 3, 32'h0F0F0F0F, 1'b0};
    vecs[4] = '{3, 1'b1, 22'h155555, 15, 1'b0, 1'b0, 1'b0, 32'h11111111, 9, 32'h00000000, 1'b1};
    vecs[5] = '{1, 1'b1, 22'h000ABC, 8,  1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 9, 32'hCAFEF00D, 1'b0};
    vecs[6] = '{2, 1'b0, 22'h000002, 9,  1'b0, 1'b0, 1'b0, 32'h22222222, 9, 32'h00000000, 1'b1};
    vecs[7] = '{0, 1'b1, 22'h222222, 5,  1'b0, 1'b1, 1'b0, 32'h87654321, 6, 32'h87654321, 1'b0};

    RESET96 = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_cs[d] = 4'b0000; req_half[d] = 4'b0000; req_addr[d] = 88'd0;
      ok_drv[d] = 2'b00; auto_ok[d] = 1'b0;
      gfx0_dout[d] = 32'd0; gfx1_dout[d] = 32'd0;
    end
    ea0 = 22'd0;
    ea1 = 22'd0;
    repeat (2) @(posedge CLK96);
    #1 RESET96 = 1'b0;
    @(posedge CLK96); #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_gfx_cs", d), gfx_cs[d], 2'b00);
      chk($sformatf("rst%0d_addr", d), {gfx1_addr[d], gfx0_addr[d]}, 44'd0);
      chk($sformatf("rst%0d_req_ok", d), req_ok[d], 4'b0000);
      chk($sformatf("rst%0d_req_data", d), req_data[d], 32'd0);
      chk($sformatf("rst%0d_err_busy", d), {tmo_err[d], busy[d]}, 2'b00);
    end

    // Round-robin, everyone requesting, slot answers as soon as it is selected.
    auto_ok[1] = 1'b1;
    req_half[1] = 4'b0101;
    req_addr[1] = {22'h000004, 22'h000003, 22'h000001, 22'h000002};
    gfx0_dout[1] = 32'h5555AAAA;
    gfx1_dout[1] = 32'hAAAA5555;
    req_cs[1] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ok(1, okv);
      chk($sformatf("rr_grant%0d", i), okv, 4'b0001 << (i % 4));
    end

    // Next fetch (requester 1, lower slot) is left hanging and then reset.
    auto_ok[1] = 1'b0;
    repeat (2) begin
      @(posedge CLK96); #1;
    end
    chk("rr_next_cs", gfx_cs[1], 2'b01);
    chk("rr_next_addr", gfx0_addr[1], 22'h000001);
    @(posedge CLK96); #1;
    #3 RESET96 = 1'b1;
    #1;
    chk("rst_mid_cs_async", gfx_cs[1], 2'b00);
    chk("rst_mid_busy", busy[1], 1'b0);
    @(posedge CLK96); #1;
    chk("rst_mid_no_ok", req_ok[1], 4'b0000);
    RESET96 = 1'b0;
    auto_ok[1] = 1'b1;
    wait_ok(1, okv);
    chk("rst_first_grant", okv, 4'b0001);
    req_cs[1] = 4'b0000;
    repeat (2) @(posedge CLK96);
    #1 auto_ok[1] = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Sprite priority starves scr0 until the sprite lets go.
    auto_ok[0] = 1'b1;
    req_half[0] = 4'b0000;
    req_cs[0] = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_ok(0, okv);
      chk($sformatf("prio_sprite%0d", i), okv, 4'b0001);
    end
    req_cs[0] = 4'b0010;
    wait_ok(0, okv);
    chk("prio_scr0_after_drop", okv, 4'b0010);
    req_cs[0] = 4'b0000;
    repeat (2) @(posedge CLK96);
    #1 auto_ok[0] = 1'b0;

    run_random(0, 1'b1, 400);
    run_random(1, 1'b0, 400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
